// File: rtl/lieat_vsetvl_unit_pkg.sv
// Shared constants, vtype field layout and payload types for the vsetvl execution unit.
// Optional build macro: LIEAT_VSETVL_FRAC_LMUL_EN (fractional LMUL support).
package lieat_vsetvl_unit_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned VLEN = 128;
    localparam int unsigned ELEN = 64;
    localparam int unsigned VL_W = 5;

    // vtype field offsets
    localparam int unsigned VTYPE_VLMUL_LSB = 0;
    localparam int unsigned VTYPE_VSEW_LSB  = 3;
    localparam int unsigned VTYPE_VTA_BIT   = 6;
    localparam int unsigned VTYPE_VMA_BIT   = 7;
    localparam int unsigned VTYPE_RSV_LSB   = 8;
    localparam int unsigned VTYPE_VILL_BIT  = XLEN - 1;

    // largest legal vsew encoding (SEW = ELEN) and VLMAX at LMUL = 1, SEW = 8
    localparam int unsigned VSEW_MAX    = $clog2(ELEN / 8);
    localparam int unsigned VLMAX_LMUL1 = VLEN / 8;

    localparam logic [XLEN-1:0] VILL_VTYPE       = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] VTYPE_FIELD_MASK = XLEN'(255);

    typedef enum logic [1:0] {
        OP_AVL     = 2'd0,
        OP_VLMAX   = 2'd1,
        OP_KEEP_VL = 2'd2
    } op_kind_e;

    typedef struct packed {
        logic [XLEN-1:0] avl;
        logic [XLEN-1:0] vtype;
        op_kind_e        kind;
        logic [4:0]      rd_idx;
    } s1_op_t;

    typedef struct packed {
        logic [4:0]      rd_idx;
        logic            rd_wen;
        logic [VL_W-1:0] vl;
    } s2_res_t;

    // vsetivli never treats rs1 as x0; otherwise rs1=x0 selects VLMAX or keep-vl by rd
    function automatic op_kind_e op_kind(input logic [4:0] rs1_idx, input logic [4:0] rd_idx,
                                         input logic is_imm);
        op_kind_e k;
        if (is_imm || (rs1_idx != 5'd0)) k = OP_AVL;
        else if (rd_idx != 5'd0)         k = OP_VLMAX;
        else                             k = OP_KEEP_VL;
        return k;
    endfunction

endpackage

// File: rtl/lieat_vsetvl_unit_if.sv
// Issue, CSR write and writeback signals of the vsetvl unit; slave = unit side.
interface lieat_vsetvl_unit_if;
    import lieat_vsetvl_unit_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_avl;
    logic [XLEN-1:0] in_vtype;
    logic [4:0]      in_rs1_idx;
    logic            in_is_imm_avl;
    logic [4:0]      in_rd_idx;
    logic            flush;
    logic [VL_W-1:0] csr_vl_rdata;
    logic            csr_vl_wen;
    logic [VL_W-1:0] csr_vl_wdata;
    logic            csr_vtype_wen;
    logic [XLEN-1:0] csr_vtype_wdata;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      out_rd_idx;
    logic            out_rd_wen;
    logic [XLEN-1:0] out_rd_wdata;

    modport master (
        output in_valid, in_avl, in_vtype, in_rs1_idx, in_is_imm_avl, in_rd_idx, flush,
        output csr_vl_rdata, out_ready,
        input  in_ready, csr_vl_wen, csr_vl_wdata, csr_vtype_wen, csr_vtype_wdata,
        input  out_valid, out_rd_idx, out_rd_wen, out_rd_wdata
    );

    modport slave (
        input  in_valid, in_avl, in_vtype, in_rs1_idx, in_is_imm_avl, in_rd_idx, flush,
        input  csr_vl_rdata, out_ready,
        output in_ready, csr_vl_wen, csr_vl_wdata, csr_vtype_wen, csr_vtype_wdata,
        output out_valid, out_rd_idx, out_rd_wen, out_rd_wdata
    );

endinterface

// File: rtl/lieat_general_dfflr.sv
// Generic load-enabled flop bank with asynchronous active-high clear.
module lieat_general_dfflr #(
    parameter int unsigned DW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       qout <= '0;
        else if (lden) qout <= dnxt;
    end

endmodule

// File: rtl/lieat_vsetvl_vlmax.sv
// Maps a requested vtype to {vill, VLMAX} and the legalised vtype to write back.
// Fractional LMUL is legal only when LIEAT_VSETVL_FRAC_LMUL_EN is defined.
module lieat_vsetvl_vlmax
    import lieat_vsetvl_unit_pkg::*;
(
    input  logic [XLEN-1:0] vtype,
    output logic            vill,
    output logic [VL_W-1:0] vlmax,
    output logic [XLEN-1:0] vtype_legal
);

    logic [2:0]      vlmul;
    logic [2:0]      vsew;
    logic            rsv_nz;
    logic            lmul_ok;
    logic [VL_W-1:0] base;
    logic [VL_W-1:0] scaled;
`ifdef LIEAT_VSETVL_FRAC_LMUL_EN
    logic            frac;
    logic [2:0]      shift;
`endif

    always_comb begin
        vlmul  = vtype[VTYPE_VLMUL_LSB +: 3];
        vsew   = vtype[VTYPE_VSEW_LSB +: 3];
        rsv_nz = |vtype[XLEN-2:VTYPE_RSV_LSB];
        base   = VL_W'(VLMAX_LMUL1 >> vsew[1:0]);
`ifdef LIEAT_VSETVL_FRAC_LMUL_EN
        // vlmul 5/6/7 divide by 8/4/2; SEW <= LMUL*ELEN reduces to vsew + shift <= 3
        frac    = (vlmul >= 3'd5);
        shift   = frac ? 3'(4'd8 - {1'b0, vlmul}) : 3'd0;
        scaled  = base >> shift;
        lmul_ok = (vlmul == 3'd0) ||
                  (frac && (({1'b0, vsew} + {1'b0, shift}) <= 4'(VSEW_MAX)));
`else
        scaled  = base;
        lmul_ok = (vlmul == 3'd0);
`endif
        vill        = rsv_nz || (vsew > 3'(VSEW_MAX)) || !lmul_ok || (scaled == '0);
        vlmax       = vill ? '0 : scaled;
        vtype_legal = vill ? VILL_VTYPE : (vtype & VTYPE_FIELD_MASK);
    end

endmodule

// File: rtl/lieat_vsetvl_unit.sv
// Two-stage vsetvl/vsetvli/vsetivli unit: S1 computes vl/vtype and writes the CSRs, S2 returns rd.
// Optional build macro: LIEAT_VSETVL_FRAC_LMUL_EN (fractional LMUL support).
module lieat_vsetvl_unit
    import lieat_vsetvl_unit_pkg::*;
(
    input logic                clock,
    input logic                reset,
    lieat_vsetvl_unit_if.slave bus
);

    logic            s1_valid, s1_valid_nxt;
    logic            s2_valid, s2_valid_nxt;
    s1_op_t          s1_nxt, s1_q;
    s2_res_t         s2_nxt, s2_q;
    logic            accept, s1_adv, s1_move;
    logic            vill;
    logic [VL_W-1:0] vlmax, vl_new;
    logic [XLEN-1:0] vtype_new;

    // handshake: S1 moves when S2 is empty or draining; flush kills the move
    assign s1_adv       = s1_valid && (!s2_valid || bus.out_ready);
    assign bus.in_ready = !s1_valid || s1_adv;
    assign accept       = bus.in_valid && bus.in_ready && !bus.flush;
    assign s1_move      = s1_adv && !bus.flush;

    always_comb begin
        s1_nxt        = '0;
        s1_nxt.avl    = bus.in_avl;
        s1_nxt.vtype  = bus.in_vtype;
        s1_nxt.kind   = op_kind(bus.in_rs1_idx, bus.in_rd_idx, bus.in_is_imm_avl);
        s1_nxt.rd_idx = bus.in_rd_idx;
    end

    always_comb begin
        s1_valid_nxt = s1_valid;
        s2_valid_nxt = s2_valid;
        if (bus.flush) begin
            s1_valid_nxt = 1'b0;
            s2_valid_nxt = 1'b0;
        end else begin
            if (accept)      s1_valid_nxt = 1'b1;
            else if (s1_adv) s1_valid_nxt = 1'b0;
            if (s1_move)                            s2_valid_nxt = 1'b1;
            else if (s2_valid && bus.out_ready)     s2_valid_nxt = 1'b0;
        end
    end

    lieat_general_dfflr #(.DW(1)) u_s1_vld (
        .clk(clock), .rst(reset), .lden(1'b1), .dnxt(s1_valid_nxt), .qout(s1_valid)
    );
    lieat_general_dfflr #(.DW($bits(s1_op_t))) u_s1_op (
        .clk(clock), .rst(reset), .lden(accept), .dnxt(s1_nxt), .qout(s1_q)
    );
    lieat_general_dfflr #(.DW(1)) u_s2_vld (
        .clk(clock), .rst(reset), .lden(1'b1), .dnxt(s2_valid_nxt), .qout(s2_valid)
    );
    lieat_general_dfflr #(.DW($bits(s2_res_t))) u_s2_res (
        .clk(clock), .rst(reset), .lden(s1_move), .dnxt(s2_nxt), .qout(s2_q)
    );

    lieat_vsetvl_vlmax u_vlmax (
        .vtype(s1_q.vtype), .vill(vill), .vlmax(vlmax), .vtype_legal(vtype_new)
    );

    // keep-vl reads the CSR in the S1 cycle so a predecessor's write is already visible
    always_comb begin
        case (s1_q.kind)
            OP_VLMAX:   vl_new = vlmax;
            OP_KEEP_VL: vl_new = (bus.csr_vl_rdata < vlmax) ? bus.csr_vl_rdata : vlmax;
            default:    vl_new = (s1_q.avl < XLEN'(vlmax)) ? VL_W'(s1_q.avl) : vlmax;
        endcase
        if (vill) vl_new = '0;
    end

    always_comb begin
        s2_nxt        = '0;
        s2_nxt.rd_idx = s1_q.rd_idx;
        s2_nxt.rd_wen = (s1_q.rd_idx != 5'd0);
        s2_nxt.vl     = vl_new;
    end

    assign bus.csr_vl_wen      = s1_move;
    assign bus.csr_vtype_wen   = s1_move;
    assign bus.csr_vl_wdata    = vl_new;
    assign bus.csr_vtype_wdata = vtype_new;
    assign bus.out_valid       = s2_valid;
    assign bus.out_rd_idx      = s2_q.rd_idx;
    assign bus.out_rd_wen      = s2_q.rd_wen;
    assign bus.out_rd_wdata    = XLEN'(s2_q.vl);

endmodule
